// File: rtl/draw_rect_char.sv
// Text-window overlay stage: 16x16 characters of 8x16 glyphs drawn over the VGA RGB stream.
// Build option CHAR_BG_FILL_EN: glyph-background pixels take BG_COLOR (opaque box) instead of rgb_in.
module draw_rect_char #(
   parameter int          XPOS     = 600,
   parameter int          YPOS     = 100,
   parameter int          COLS     = 16,
   parameter int          ROWS     = 16,
   parameter logic [11:0] FG_COLOR = 12'hEFF,
   parameter logic [11:0] BG_COLOR = 12'h60D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   input  logic [6:0]  char_code,
   output logic [3:0]  char_line,
   input  logic [7:0]  char_pixels,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam logic [10:0] X_LO = 11'(XPOS);
   localparam logic [10:0] X_HI = 11'(XPOS + COLS * 8);
   localparam logic [10:0] Y_LO = 11'(YPOS);
   localparam logic [10:0] Y_HI = 11'(YPOS + ROWS * 16);

`ifdef CHAR_BG_FILL_EN
   localparam bit BG_FILL = 1'b1;
`else
   localparam bit BG_FILL = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } timing_t;

   // Streaming stage: no valid/ready handshake, one pixel enters and one leaves every clock.
   timing_t    t_in, t1, t2, t3;
   logic       inside_in, inside1, inside2, inside3;
   logic [6:0] hrel;
   logic [7:0] vrel;
   logic [2:0] hrel1, hrel2, hrel3;
   logic [3:0] vrel1;
   logic       glyph_bit;
   logic [11:0] rgb_next;

   assign t_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, vsync: vsync_in,
                   hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

   // Only the low bits of the offsets are consumed; wrapped values are masked by inside.
   assign hrel      = hcount_in[6:0] - X_LO[6:0];
   assign vrel      = vcount_in[7:0] - Y_LO[7:0];
   assign inside_in = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                      (vcount_in >= Y_LO) && (vcount_in < Y_HI);

   assign glyph_bit = char_pixels[3'd7 - hrel3];

   always_comb begin
      rgb_next = t3.rgb;
      if (t3.hblnk || t3.vblnk)
         rgb_next = 12'h000;
      else if (inside3 && glyph_bit)
         rgb_next = FG_COLOR;
      else if (inside3)
         rgb_next = BG_FILL ? BG_COLOR : t3.rgb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t1         <= '0;
         t2         <= '0;
         t3         <= '0;
         inside1    <= 1'b0;
         inside2    <= 1'b0;
         inside3    <= 1'b0;
         hrel1      <= '0;
         hrel2      <= '0;
         hrel3      <= '0;
         vrel1      <= '0;
         char_xy    <= '0;
         char_line  <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         // S1: window test and character-ROM address
         t1      <= t_in;
         inside1 <= inside_in;
         hrel1   <= hrel[2:0];
         vrel1   <= vrel[3:0];
         char_xy <= {vrel[7:4], hrel[6:3]};
         // S2: char_code arrives; glyph line presented alongside it
         t2        <= t1;
         inside2   <= inside1;
         hrel2     <= hrel1;
         char_line <= vrel1;
         // S3: char_pixels arrives
         t3      <= t2;
         inside3 <= inside2;
         hrel3   <= hrel2;
         // S4: registered outputs
         hcount_out <= t3.hcount;
         vcount_out <= t3.vcount;
         hsync_out  <= t3.hsync;
         vsync_out  <= t3.vsync;
         hblnk_out  <= t3.hblnk;
         vblnk_out  <= t3.vblnk;
         rgb_out    <= rgb_next;
      end
   end

endmodule

// File: doc/draw_rect_char.md
Name: draw_rect_char

Overview:
- Pixel-pipeline stage directly downstream of the VGA timing generator.
- Overlays a 16x16-character text window, using 8x16 glyphs, on the incoming RGB stream.
- Drives the address of an external character-code ROM and consumes an external font ROM.
- Delays all timing signals so they stay aligned with the RGB it produces.

Parameters:
- XPOS, 600, left pixel column of the text window.
- YPOS, 100, top pixel row of the text window.
- COLS, 16, characters per row; the window is COLS*8 pixels wide.
- ROWS, 16, character rows; the window is ROWS*16 pixels high.
- FG_COLOR, 12'hEFF, glyph foreground colour.
- BG_COLOR, 12'h60D, window background colour (used only with the optional feature).

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  synchronous reset, active-high
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- hblnk_in  in  1  horizontal blanking
- vblnk_in  in  1  vertical blanking
- rgb_in  in  12  upstream colour, 12'hRGB
- char_xy  out  8  character-ROM address {row[3:0], col[3:0]}
- char_code  in  7  ASCII code from the character ROM; registered ROM, 1-cycle latency
- char_line  out  4  glyph line index, aligned with char_code
- char_pixels  in  8  font ROM row for {char_code, char_line}; registered ROM, 1-cycle latency; bit 7 is the leftmost pixel
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing signals delayed by 4 cycles
- rgb_out  out  12  output colour

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset:
  - All outputs and internal pipeline registers are 0 on the first clk edge with rst=1.
  - Reset mid-frame flushes the pipeline.
  - After release, outputs reflect new inputs after exactly 4 cycles; no stale pixel may leak.
- Pipeline, for an input sample at edge N:
  - S1 (N+1):
    - inside = (hcount_in >= XPOS) && (hcount_in < XPOS+COLS*8) && (vcount_in >= YPOS) && (vcount_in < YPOS+ROWS*16).
    - hrel = hcount_in - XPOS; vrel = vcount_in - YPOS. Subtraction is 11-bit; a wrapped value is masked by inside=0.
    - char_xy = {vrel[7:4], hrel[6:3]}.
  - S2 (N+2): char_code is valid. char_line = vrel[3:0], delayed one cycle to align with char_code.
  - S3 (N+3): char_pixels is valid. Selected bit = char_pixels[7 - hrel[2:0]], using hrel delayed to S3.
  - S4 (N+4): rgb_out and all *_out timing signals are registered.
- Colour select at S4, in priority order:
  - hblnk or vblnk delayed → 12'h000.
  - else inside delayed and selected bit = 1 → FG_COLOR.
  - else inside delayed and bit = 0 → see Optional Feature.
  - else → rgb_in delayed by 4.
- char_xy and char_line are don't-care outside the window, but must be deterministic (no X).
- The pipeline has no stall or handshake; one pixel is accepted and one produced every cycle.
- hcount/vcount wrap-around (1055→0, 627→0) needs no special handling; all data moves through the pipeline unchanged.
- Window edges are inclusive at XPOS/YPOS and exclusive at XPOS+128/YPOS+256.

Optional Feature:
- Macro: CHAR_BG_FILL_EN.
- Defined: glyph-background pixels inside the window output BG_COLOR, giving an opaque text box.
- Undefined: glyph-background pixels output rgb_in delayed by 4, so the text is transparent.
- Foreground, blanking and outside-window behaviour is identical in both builds.

Test Plan:
- Latency:
  - Stimulus: rst pulsed, then hcount_in=5, vcount_in=5, hsync_in=1, rgb_in=12'h123, no blanking.
  - Required: 4 cycles later hcount_out=5, hsync_out=1, rgb_out=12'h123. All outputs are 0 during reset.
- Address generation:
  - Stimulus: hcount_in=600+8*3+2=626, vcount_in=100+16*5+7=187.
  - Required: char_xy=8'h53 one cycle later, char_line=4'h7 two cycles later.
- Glyph pixel:
  - Stimulus: char ROM model returns 7'h41; font model returns 8'b0010_0000 for the addressed line. hcount_in=602 (hrel[2:0]=2), vcount_in=100.
  - Required: rgb_out=12'hEFF. At hcount_in=603: 12'h60D with CHAR_BG_FILL_EN, rgb_in without it.
- Window edges:
  - hcount_in=599 or 728 → rgb_out=rgb_in.
  - hcount_in=600 and hcount_in=727 with vcount_in=355 → inside the window.
  - vcount_in=356 → outside.
- Blanking: hblnk_in=1 inside window coordinates with an all-ones glyph → rgb_out=12'h000.
- Mid-frame reset: rst asserted for 1 cycle during a glyph row → outputs 0 for the next 4 cycles, then correct pixels resume.
